unidade_controle: RTL

//   Sequencer that drives the 5-bit tx command bus of the program memory and steps

---
 rtl/veritop_pkg.sv | 28 ++
 rtl/unidade_controle_if.sv | 33 +++
 rtl/unidade_controle_timeout.sv | 32 +++
 rtl/unidade_controle.sv | 128 ++++++++++++
 4 files changed

// File: rtl/veritop_pkg.sv
// veritop_pkg
//   Shared constants for the program sequencer: memory command codes driven on
//   tx, instruction codes returned on entrada, and the state encoding that is
//   exported on etapa.
package veritop_pkg;

  localparam logic [4:0] TX_NOP  = 5'd0;
  localparam logic [4:0] TX_LOAD = 5'd1;
  localparam logic [4:0] TX_EXEC = 5'd2;

  localparam logic [4:0] OP_A    = 5'd2;
  localparam logic [4:0] OP_B    = 5'd3;
  localparam logic [4:0] OP_END  = 5'd5;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'd0,
    ST_FETCH  = 5'd1,
    ST_DECODE = 5'd2,
    ST_EXEC   = 5'd3,
    ST_FINISH = 5'd4
  } state_t;

  // True for codes that are handed to the datapath as an operation.
  function automatic logic is_op_code(input logic [4:0] code);
    return (code == OP_A) || (code == OP_B);
  endfunction

endpackage

// File: rtl/unidade_controle_if.sv
// unidade_controle_if
//   Bundles the sequencer's control, memory and datapath signals.
//   master : the sequencer (consumes start/abort/entrada/exec_done,
//            drives tx and the status outputs)
//   slave  : the environment (top-level controls, memory, datapath)
//   Signals: start, abort, entrada[4:0], exec_done, tx[4:0], etapa[4:0],
//            op_valid, opcode[4:0], busy, done, error, op_count[CNT_W-1:0]
interface unidade_controle_if #(
  parameter int CNT_W = 5
);
  logic             start;
  logic             abort;
  logic [4:0]       entrada;
  logic             exec_done;
  logic [4:0]       tx;
  logic [4:0]       etapa;
  logic             op_valid;
  logic [4:0]       opcode;
  logic             busy;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] op_count;

  modport master (
    input  start, abort, entrada, exec_done,
    output tx, etapa, op_valid, opcode, busy, done, error, op_count
  );

  modport slave (
    output start, abort, entrada, exec_done,
    input  tx, etapa, op_valid, opcode, busy, done, error, op_count
  );
endinterface

// File: rtl/unidade_controle_timeout.sv
// contador_timeout
//   Counts EXEC cycles and flags when the count reaches TIMEOUT-1.
//   Ports: clock, reset_n (async, active-low), clear (sync zero),
//          enable (count one per cycle), expired (count == TIMEOUT-1).
module contador_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Holds at LAST so the counter can never wrap back under the limit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/unidade_controle.sv
// unidade_controle
//   Fetch/decode/execute sequencer for the program memory. Issues LOAD on tx,
//   decodes the returned entrada code, hands OP_A/OP_B to the datapath and waits
//   for exec_done, looping until OP_END. abort returns to IDLE from any busy
//   state; a bad code or an EXEC timeout sets the sticky error flag.
//   Ports: clock, reset_n (async, active-low), bus (unidade_controle_if.master).
module unidade_controle
  import veritop_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  unidade_controle_if.master    bus
);

  state_t           state;
  state_t           state_nxt;
  logic [4:0]       opcode_q;
  logic [CNT_W-1:0] op_count_q;
  logic             error_q;
  logic             run_clear;
  logic             op_inc;
  logic             err_set;
  logic             expired;

  contador_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (state == ST_DECODE),
    .enable  (state == ST_EXEC),
    .expired (expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // abort is tested first in every busy state so it overrides exec_done,
  // timeout and decode outcomes alike.
  always_comb begin
    state_nxt = state;
    run_clear = 1'b0;
    op_inc    = 1'b0;
    err_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt = ST_FETCH;
          run_clear = 1'b1;
        end
      end
      ST_FETCH: begin
        state_nxt = bus.abort ? ST_IDLE : ST_DECODE;
      end
      ST_DECODE: begin
        if (bus.abort) begin
          state_nxt = ST_IDLE;
        end else if (is_op_code(bus.entrada)) begin
          state_nxt = ST_EXEC;
        end else if (bus.entrada == OP_END) begin
          state_nxt = ST_FINISH;
        end else begin
          state_nxt = ST_IDLE;
          err_set   = 1'b1;
        end
      end
      ST_EXEC: begin
        if (bus.abort) begin
          state_nxt = ST_IDLE;
        end else if (bus.exec_done) begin
          state_nxt = ST_FETCH;
          op_inc    = 1'b1;
        end else if (expired) begin
          state_nxt = ST_IDLE;
          err_set   = 1'b1;
        end
      end
      ST_FINISH: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      opcode_q <= '0;
    end else if (state == ST_DECODE) begin
      opcode_q <= bus.entrada;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_count_q <= '0;
      error_q    <= 1'b0;
    end else if (run_clear) begin
      op_count_q <= '0;
      error_q    <= 1'b0;
    end else begin
      if (op_inc) begin
        op_count_q <= op_count_q + CNT_W'(1);
      end
      if (err_set) begin
        error_q <= 1'b1;
      end
    end
  end

  assign bus.tx       = (state == ST_FETCH) ? TX_LOAD :
                        (state == ST_EXEC)  ? TX_EXEC : TX_NOP;
  assign bus.etapa    = state;
  assign bus.op_valid = (state == ST_EXEC);
  assign bus.busy     = (state != ST_IDLE);
  assign bus.done     = (state == ST_FINISH);
  assign bus.opcode   = opcode_q;
  assign bus.error    = error_q;
  assign bus.op_count = op_count_q;

endmodule
